// File: rtl/pipe_skid_reg_pkg.sv
// rtl/pipe_skid_reg_pkg.sv - shared stage payload layout, NOP/write-enable constants, occupancy encoding
package pipe_skid_reg_pkg;

  // Occupancy state, encoded directly as {s_valid, m_valid}
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_TWO   = 2'b11
  } occ_e;

  // Default packed payload width shared by all CPU stage registers
  localparam int PAYLOAD_W = 128;

  // Payload field offsets and widths
  localparam int F_WREG        = 0;
  localparam int F_WHILO       = 1;
  localparam int F_MREG        = 2;
  localparam int F_CP0_WE      = 3;
  localparam int F_EXCCODE_LSB = 4;
  localparam int F_EXCCODE_W   = 5;
  localparam int F_IN_DELAY    = 9;
  localparam int F_CTRL_LSB    = 16;
  localparam int F_CTRL_W      = 16;
  localparam int F_PC_LSB      = 32;
  localparam int F_PC_W        = 32;
  localparam int F_DATA_LSB    = 64;
  localparam int F_DATA_W      = 64;

  // All-zero payload decodes as SLL $0 / REG_NOP / EXC_NONE in every stage
  localparam logic [PAYLOAD_W-1:0] IFID_NOP   = '0;
  localparam logic [PAYLOAD_W-1:0] IDEXE_NOP  = '0;
  localparam logic [PAYLOAD_W-1:0] EXEMEM_NOP = '0;
  localparam logic [PAYLOAD_W-1:0] MEMWB_NOP  = '0;

  // Write-enable bits that must be hidden while a stage holds a bubble
  localparam logic [PAYLOAD_W-1:0] IFID_WE_MASK   = '0;
  localparam logic [PAYLOAD_W-1:0] IDEXE_WE_MASK  = PAYLOAD_W'(1) << F_WREG;
  localparam logic [PAYLOAD_W-1:0] EXEMEM_WE_MASK = (PAYLOAD_W'(1) << F_WREG)  |
                                                    (PAYLOAD_W'(1) << F_WHILO) |
                                                    (PAYLOAD_W'(1) << F_MREG)  |
                                                    (PAYLOAD_W'(1) << F_CP0_WE);
  localparam logic [PAYLOAD_W-1:0] MEMWB_WE_MASK  = (PAYLOAD_W'(1) << F_WREG) |
                                                    (PAYLOAD_W'(1) << F_WHILO);

  // Number of entries held, from the two valid flags
  function automatic logic [1:0] occ_count(input logic m_valid, input logic s_valid);
    return {1'b0, m_valid} + {1'b0, s_valid};
  endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// rtl/pipe_skid_reg_if.sv - valid/ready stage handshake bundle with status outputs
interface pipe_skid_reg_if #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  // Environment side: produces upstream payloads, consumes downstream
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy, stall_cnt
  );

  // Stage register side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy, stall_cnt
  );
endinterface

// File: rtl/pipe_sat_cnt.sv
// rtl/pipe_sat_cnt.sv - saturating up-counter with asynchronous active-high clear
module pipe_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;

  // Count up on inc, stick at all-ones rather than wrapping
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - valid/ready pipeline stage register with optional 2-entry skid buffer
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int                 DATA_W    = 128,
  parameter logic [DATA_W-1:0]  NOP_VALUE = {DATA_W{1'b0}},
  parameter logic [DATA_W-1:0]  WE_MASK   = {DATA_W{1'b0}},
  parameter int                 SKID      = 1,
  parameter int                 CNT_W     = 16
) (
  input  logic            cpu_clk_50M,
  input  logic            cpu_rst,
  input  logic            flush,
  pipe_skid_reg_if.slave  bus
);
  logic              m_valid_q, m_valid_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;
  logic              in_ready;
  logic              in_fire;
  logic              out_fire;
  occ_e              state;

  assign state = occ_e'({s_valid_q, m_valid_q});

  // With the skid entry, ready depends only on state; without it, a full
  // main register can still accept when downstream drains it this cycle.
  if (SKID != 0) begin : g_skid_ready
    assign in_ready = ~s_valid_q;
  end else begin : g_flow_ready
    assign in_ready = ~m_valid_q | bus.out_ready;
  end

  assign in_fire  = bus.in_valid & in_ready;
  assign out_fire = m_valid_q & bus.out_ready;

  // Storage registers; reset and flush both return to an empty NOP stage
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_data_q  <= NOP_VALUE;
      s_data_q  <= NOP_VALUE;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
    end
  end

  // Next-state: flush wins over any handshake, otherwise advance the FIFO
  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_data_d  = m_data_q;
    s_data_d  = s_data_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      m_data_d  = NOP_VALUE;
      s_data_d  = NOP_VALUE;
    end else begin
      case (state)
        OCC_EMPTY: begin
          if (in_fire) begin
            m_valid_d = 1'b1;
            m_data_d  = bus.in_data;
          end
        end
        OCC_ONE: begin
          if (in_fire && out_fire) begin
            m_data_d = bus.in_data;
          end else if (out_fire) begin
            // Keep m_data; output gating hides its write enables
            m_valid_d = 1'b0;
          end else if (in_fire && (SKID != 0)) begin
            s_valid_d = 1'b1;
            s_data_d  = bus.in_data;
          end
        end
        OCC_TWO: begin
          if (out_fire) begin
            m_data_d  = s_data_q;
            s_valid_d = 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk_i (cpu_clk_50M),
    .clr_i (cpu_rst),
    .inc_i (m_valid_q & ~bus.out_ready),
    .cnt_o (bus.stall_cnt)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = m_valid_q;
  assign bus.out_data  = m_data_q & ~(WE_MASK & {DATA_W{~m_valid_q}});
  assign bus.occupancy = occ_count(m_valid_q, s_valid_q);
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - randomized and directed bench for pipe_skid_reg against a FIFO model
module tb_pipe_skid_reg;
  localparam int              DW  = 8;
  localparam int              CW  = 4;
  localparam logic [DW-1:0]   NOP = 8'hA5;
  localparam logic [DW-1:0]   WEM = 8'h01;
  localparam int              SAT = 15;

  logic clk;
  logic rst;
  logic flush_r;

  // Index 0: SKID=0 instance, index 1: SKID=1 instance
  logic          iv   [2];
  logic [DW-1:0] id   [2];
  logic          ordy [2];
  logic          ov   [2];
  logic [DW-1:0] od   [2];
  logic          ir   [2];
  logic [1:0]    oc   [2];
  logic [CW-1:0] sc   [2];

  // Reference model: a FIFO of capacity 1 or 2 plus the value last held at the head
  logic [DW-1:0] mq    [2][2];
  int            mcnt  [2];
  logic [DW-1:0] mhold [2];
  int            mstall[2];

  int n_checks;
  int n_errors;

  pipe_skid_reg_if #(.DATA_W(DW), .CNT_W(CW)) if0 ();
  pipe_skid_reg_if #(.DATA_W(DW), .CNT_W(CW)) if1 ();

  assign if0.in_valid  = iv[0];
  assign if0.in_data   = id[0];
  assign if0.out_ready = ordy[0];
  assign if1.in_valid  = iv[1];
  assign if1.in_data   = id[1];
  assign if1.out_ready = ordy[1];
  assign ov[0] = if0.out_valid;
  assign od[0] = if0.out_data;
  assign ir[0] = if0.in_ready;
  assign oc[0] = if0.occupancy;
  assign sc[0] = if0.stall_cnt;
  assign ov[1] = if1.out_valid;
  assign od[1] = if1.out_data;
  assign ir[1] = if1.in_ready;
  assign oc[1] = if1.occupancy;
  assign sc[1] = if1.stall_cnt;

  pipe_skid_reg #(.DATA_W(DW), .NOP_VALUE(NOP), .WE_MASK(WEM), .SKID(0), .CNT_W(CW)) u_dut0 (
    .cpu_clk_50M (clk),
    .cpu_rst     (rst),
    .flush       (flush_r),
    .bus         (if0)
  );

  pipe_skid_reg #(.DATA_W(DW), .NOP_VALUE(NOP), .WE_MASK(WEM), .SKID(1), .CNT_W(CW)) u_dut1 (
    .cpu_clk_50M (clk),
    .cpu_rst     (rst),
    .flush       (flush_r),
    .bus         (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic model_ready(input int k);
    if (k == 1) return mcnt[k] < 2;
    return (mcnt[k] == 0) || ordy[k];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mcnt[k]   = 0;
      mhold[k]  = NOP;
      mstall[k] = 0;
    end
  endtask

  // Compare outputs mid-cycle, advance the model, then cross the clock edge
  task automatic step();
    logic exp_v;
    logic in_f;
    logic out_f;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      exp_v = mcnt[k] > 0;
      chk($sformatf("out_valid%0d", k), 32'(ov[k]), 32'(exp_v));
      chk($sformatf("out_data%0d", k),  32'(od[k]), exp_v ? 32'(mhold[k]) : 32'(mhold[k] & ~WEM));
      chk($sformatf("in_ready%0d", k),  32'(ir[k]), 32'(model_ready(k)));
      chk($sformatf("occupancy%0d", k), 32'(oc[k]), 32'(mcnt[k]));
      chk($sformatf("stall_cnt%0d", k), 32'(sc[k]), 32'(mstall[k]));
    end
    for (int k = 0; k < 2; k++) begin
      in_f  = iv[k] && model_ready(k);
      out_f = (mcnt[k] > 0) && ordy[k];
      if ((mcnt[k] > 0) && !ordy[k] && (mstall[k] < SAT)) mstall[k]++;
      if (flush_r) begin
        mcnt[k]  = 0;
        mhold[k] = NOP;
      end else begin
        if (out_f) begin
          mq[k][0] = mq[k][1];
          mcnt[k]--;
        end
        if (in_f) begin
          mq[k][mcnt[k]] = id[k];
          mcnt[k]++;
        end
        if (mcnt[k] > 0) mhold[k] = mq[k][0];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [DW-1:0] d, input logic r);
    for (int k = 0; k < 2; k++) begin
      iv[k]   = v;
      id[k]   = d;
      ordy[k] = r;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    flush_r  = 1'b0;
    set_in(1'b0, '0, 1'b0);
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, idle
    step();
    step();

    // Streaming 1..6 with downstream always ready
    for (int i = 1; i <= 6; i++) begin
      set_in(1'b1, DW'(i), 1'b1);
      step();
    end
    set_in(1'b0, '0, 1'b1);
    step();
    step();

    // Back-pressure: 0xA, 0xB while stalled, then drain
    set_in(1'b1, 8'h0A, 1'b0);
    step();
    set_in(1'b1, 8'h0B, 1'b0);
    step();
    set_in(1'b0, '0, 1'b0);
    step();
    step();
    set_in(1'b0, '0, 1'b1);
    repeat (3) step();

    // Flush while full with a simultaneous offered 0xC
    set_in(1'b1, 8'h03, 1'b0);
    step();
    set_in(1'b1, 8'h04, 1'b0);
    step();
    set_in(1'b1, 8'h0C, 1'b1);
    flush_r = 1'b1;
    step();
    flush_r = 1'b0;
    set_in(1'b0, '0, 1'b1);
    repeat (3) step();

    // Bubble gating after 0xFF leaves the stage
    set_in(1'b1, 8'hFF, 1'b1);
    step();
    set_in(1'b0, '0, 1'b1);
    step();
    step();
    chk("gate_data1", 32'(od[1]), 32'h0000_00FE);
    chk("gate_upper1", 32'(od[1][7:1]), 32'h0000_007F);

    // Async reset while the skid instance holds two entries
    set_in(1'b1, 8'h11, 1'b0);
    step();
    set_in(1'b1, 8'h22, 1'b0);
    step();
    chk("pre_rst_occ1", 32'(oc[1]), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_valid%0d", k), 32'(ov[k]), 32'd0);
      chk($sformatf("rst_occ%0d", k),   32'(oc[k]), 32'd0);
      chk($sformatf("rst_ready%0d", k), 32'(ir[k]), 32'd1);
      chk($sformatf("rst_stall%0d", k), 32'(sc[k]), 32'd0);
      chk($sformatf("rst_data%0d", k),  32'(od[k]), 32'(NOP & ~WEM));
    end
    model_reset();
    set_in(1'b0, '0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    // Saturation: one entry held under back-pressure for 20 cycles
    set_in(1'b1, 8'h5C, 1'b0);
    step();
    set_in(1'b0, '0, 1'b0);
    repeat (20) step();
    chk("sat_stall0", 32'(sc[0]), 32'(SAT));
    chk("sat_stall1", 32'(sc[1]), 32'(SAT));

    // Randomized traffic, occasional flush
    set_in(1'b0, '0, 1'b1);
    step();
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        iv[k]   = ($urandom_range(0, 3) != 0);
        id[k]   = DW'($urandom);
        ordy[k] = ($urandom_range(0, 2) != 0);
      end
      flush_r = ($urandom_range(0, 15) == 0);
      step();
    end
    flush_r = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
